// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: request/acknowledge data-bus FSM, byte lanes, load extraction, RF write port.
// Latency: non-memory ops take 1 cycle; loads/stores take N+2 cycles (N = REQ cycles up to and including ack).
// Backpressure: stall_mem holds upstream stages while an access is outstanding. Optional macro: MISALIGN_TRAP_EN.
module mem_wb_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_out_mem,
  input  logic [31:0]       opr_res_im_wb,
  input  logic [31:0]       rdata2_im_wb,
  input  logic [4:0]        rd_im_wb,
  input  logic              rf_en_im_wb,
  input  logic [1:0]        sel_wb_im_wb,
  input  logic              wr_en_im_wb,
  input  logic              rd_en_im_wb,
  input  logic [2:0]        mem_type_im_wb,
  input  logic [31:0]       csr_rdata,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_ack,
  input  logic [31:0]       dbus_rdata,
  output logic              stall_mem,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign_trap,
  output logic [31:0]       misalign_addr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [31:0] ld_q;

  logic        mem_instr;
  logic        is_store;
  logic [1:0]  a;
  logic [1:0]  eff_a;
  logic        size_b;
  logic        size_h;
  logic        sign_ld;
  logic        trap;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;

  // Load wins when both load and store are flagged.
  assign mem_instr = rd_en_im_wb | wr_en_im_wb;
  assign is_store  = wr_en_im_wb & ~rd_en_im_wb;
  assign a         = opr_res_im_wb[1:0];

  // Access size decode; unused codes 011/110/111 fall through to word.
  assign size_b  = (mem_type_im_wb == 3'b000) | (mem_type_im_wb == 3'b100);
  assign size_h  = (mem_type_im_wb == 3'b001) | (mem_type_im_wb == 3'b101);
  assign sign_ld = ~mem_type_im_wb[2];

  // Effective low address bits: halves are forced to even, words to zero.
  assign eff_a = size_b ? a : (size_h ? {a[1], 1'b0} : 2'b00);

  // Byte-lane enables and replicated store data for the next request.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = rdata2_im_wb;
    if (size_b) begin
      be_nxt    = 4'b0001 << a;
      wdata_nxt = {4{rdata2_im_wb[7:0]}};
    end else if (size_h) begin
      be_nxt    = 4'b0011 << {a[1], 1'b0};
      wdata_nxt = {2{rdata2_im_wb[15:0]}};
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned    = (size_h & a[0]) | (~size_b & ~size_h & (a != 2'b00));
  assign trap          = ~rst & mem_instr & misaligned;
  assign misalign_trap = trap;
  assign misalign_addr = trap ? opr_res_im_wb : 32'd0;
`else
  assign trap          = 1'b0;
  assign misalign_trap = 1'b0;
  assign misalign_addr = 32'd0;
`endif

  // Upstream is held from arrival until the DONE cycle, when the pipeline advances.
  assign stall_mem = ~rst & mem_instr & (state != DONE) & ~trap;

  // Bus FSM: registered bus outputs, loaded on IDLE->REQ and held until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_q       <= 32'd0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_be    <= 4'b0000;
      dbus_addr  <= '0;
      dbus_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_instr && !trap) begin
            state      <= REQ;
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_be    <= be_nxt;
            dbus_addr  <= {opr_res_im_wb[ADDR_W-1:2], 2'b00};
            dbus_wdata <= wdata_nxt;
          end
        end
        REQ: begin
          if (dbus_ack) begin
            ld_q     <= dbus_rdata;
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Load extraction from the captured word: align, then sign/zero extend.
  always_comb begin
    ld_shift = ld_q >> {eff_a, 3'b000};
    ld_ext   = ld_shift;
    if (size_b) begin
      ld_ext = {{24{sign_ld & ld_shift[7]}}, ld_shift[7:0]};
    end else if (size_h) begin
      ld_ext = {{16{sign_ld & ld_shift[15]}}, ld_shift[15:0]};
    end
  end

  // Writeback value select.
  always_comb begin
    wb_data = opr_res_im_wb;
    case (sel_wb_im_wb)
      2'b00:   wb_data = opr_res_im_wb;
      2'b01:   wb_data = ld_ext;
      2'b10:   wb_data = pc_out_mem + 32'd4;
      default: wb_data = csr_rdata;
    endcase
  end

  assign wb_rd = rd_im_wb;
  assign wb_en = ~rst & rf_en_im_wb & ~stall_mem & ~trap & (rd_im_wb != 5'd0);

endmodule
